// File: rtl/an_decoder_pipe_pkg.sv
// Shared widths, syndrome-table generator and parameter checks for the AN-code decoder.
package an_dec_pkg;

  typedef struct packed {
    logic       hit;
    logic       neg;
    logic [7:0] shift;
  } syn_t;

  function automatic int unsigned res_w(input int unsigned a);
    return $clog2(a);
  endfunction

  // Signed width holding W - Delta without overflow
  function automatic int unsigned dlt_w(input int unsigned cw);
    return cw + 2;
  endfunction

  // Residue r -> single arithmetic error +/-2^i; lowest i (and + before -) wins
  function automatic syn_t an_syndrome(input int unsigned a, input int unsigned cw,
                                       input int unsigned r);
    syn_t        s;
    int unsigned p;
    s = '0;
    for (int unsigned i = 0; i < cw; i++) begin
      p = (32'd1 << i) % a;
      if (!s.hit && r == p) begin
        s.hit   = 1'b1;
        s.neg   = 1'b0;
        s.shift = 8'(i);
      end else if (!s.hit && r == a - p) begin
        s.hit   = 1'b1;
        s.neg   = 1'b1;
        s.shift = 8'(i);
      end
    end
    return s;
  endfunction

  function automatic int an_delta(input syn_t s);
    int m;
    m = 1 << s.shift;
    if (!s.hit) return 0;
    return s.neg ? -m : m;
  endfunction

  function automatic bit params_ok(input int unsigned a, input int unsigned cw,
                                   input int unsigned d);
    return (a % 2 == 1) && (a >= 3) && (a * ((32'd1 << d) - 1) < (32'd1 << cw));
  endfunction

endpackage

// File: rtl/an_decoder_pipe_if.sv
// Valid/ready stream bundle between the AN datapath, the decoder and its consumer.
interface an_decoder_pipe_if #(
  parameter int unsigned CW_W = 6,
  parameter int unsigned D_W  = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [CW_W-1:0] in_w;
  logic            out_valid;
  logic            out_ready;
  logic [D_W-1:0]  out_n;
  logic            out_corr;
  logic            out_fail;

  modport master (output in_valid, in_w, out_ready,
                  input  in_ready, out_valid, out_n, out_corr, out_fail);
  modport slave  (input  in_valid, in_w, out_ready,
                  output in_ready, out_valid, out_n, out_corr, out_fail);
endinterface

// File: rtl/an_syndrome_rom.sv
// Combinational residue -> {hit, Delta} table, built at elaboration from an_syndrome().
module an_syndrome_rom
  import an_dec_pkg::*;
#(
  parameter int unsigned A    = 13,
  parameter int unsigned CW_W = 6
) (
  input  logic [res_w(A)-1:0]              res,
  output logic                             hit_c,
  output logic signed [dlt_w(CW_W)-1:0]    delta_c
);
  localparam int unsigned RES_W = res_w(A);
  localparam int unsigned DLT_W = dlt_w(CW_W);
  localparam int unsigned DEPTH = 2 ** RES_W;

  logic                    hit_tab [DEPTH];
  logic signed [DLT_W-1:0] dlt_tab [DEPTH];

  // Residue 0 is a clean codeword; residues >= A never occur and read as misses
  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    localparam syn_t S = an_syndrome(A, CW_W, g);
    assign hit_tab[g] = (g == 0) || S.hit;
    assign dlt_tab[g] = DLT_W'(an_delta(S));
  end

  assign hit_c   = hit_tab[res];
  assign delta_c = dlt_tab[res];
endmodule

// File: rtl/an_decoder_pipe.sv
// Three-stage single-AWE AN-code decoder (residue / correct / divide) with stream backpressure.
// Optional saturating correction/failure counters under `AN_DEC_STATS_EN.
module an_decoder_pipe
  import an_dec_pkg::*;
#(
  parameter int unsigned A    = 13,
  parameter int unsigned CW_W = 6,
  parameter int unsigned D_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  an_decoder_pipe_if.slave  bus
`ifdef AN_DEC_STATS_EN
  ,
  output logic [15:0]       cnt_corr,
  output logic [15:0]       cnt_fail
`endif
);
  localparam int unsigned RES_W = res_w(A);
  localparam int unsigned DLT_W = dlt_w(CW_W);
  localparam logic signed [DLT_W-1:0] C_MAX = DLT_W'(A * ((2 ** D_W) - 1));

  if (!params_ok(A, CW_W, D_W)) begin : g_param_err
    $error("an_decoder_pipe: A must be odd >= 3 and A*(2^D_W-1) < 2^CW_W");
  end

  logic adv_c;
  assign adv_c        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv_c;

  // S1: capture word and its residue
  logic             v1;
  logic [CW_W-1:0]  w1;
  logic [RES_W-1:0] r1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      w1 <= '0;
      r1 <= '0;
    end else if (adv_c) begin
      v1 <= bus.in_valid;
      w1 <= bus.in_w;
      r1 <= RES_W'(bus.in_w % A);
    end
  end

  // S2: syndrome lookup, correction and range check
  logic                    hit_c;
  logic signed [DLT_W-1:0] delta_c;
  logic signed [DLT_W-1:0] c_c;
  logic                    fail_c;
  logic                    corr_c;

  an_syndrome_rom #(.A(A), .CW_W(CW_W)) u_rom (
    .res     (r1),
    .hit_c   (hit_c),
    .delta_c (delta_c)
  );

  assign c_c    = $signed({2'b00, w1}) - delta_c;
  assign fail_c = !hit_c || c_c[DLT_W-1] || (c_c > C_MAX);
  assign corr_c = (delta_c != '0) && !fail_c;

  logic            v2;
  logic [CW_W-1:0] c2;
  logic            corr2;
  logic            fail2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      c2    <= '0;
      corr2 <= 1'b0;
      fail2 <= 1'b0;
    end else if (adv_c) begin
      v2    <= v1;
      c2    <= c_c[CW_W-1:0];
      corr2 <= corr_c;
      fail2 <= fail_c;
    end
  end

  // S3: exact division by the constant multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_n     <= '0;
      bus.out_corr  <= 1'b0;
      bus.out_fail  <= 1'b0;
    end else if (adv_c) begin
      bus.out_valid <= v2;
      bus.out_n     <= fail2 ? '0 : D_W'(c2 / A);
      bus.out_corr  <= corr2;
      bus.out_fail  <= fail2;
    end
  end

`ifdef AN_DEC_STATS_EN
  logic retire_c;
  assign retire_c = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr <= '0;
      cnt_fail <= '0;
    end else if (retire_c) begin
      if (bus.out_corr && cnt_corr != 16'hFFFF) cnt_corr <= cnt_corr + 16'd1;
      if (bus.out_fail && cnt_fail != 16'hFFFF) cnt_fail <= cnt_fail + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_an_decoder_pipe.sv
// Self-checking bench for an_decoder_pipe (A=13, CW_W=6, D_W=2); define AN_DEC_STATS_EN to cover counters.
module tb_an_decoder_pipe;
  localparam int unsigned A    = 13;
  localparam int unsigned CW_W = 6;
  localparam int unsigned D_W  = 2;
  localparam int          SA   = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  an_decoder_pipe_if #(.CW_W(CW_W), .D_W(D_W)) bus ();

`ifdef AN_DEC_STATS_EN
  logic [15:0] cnt_corr, cnt_fail;
`endif

  an_decoder_pipe #(.A(A), .CW_W(CW_W), .D_W(D_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef AN_DEC_STATS_EN
    ,
    .cnt_corr (cnt_corr),
    .cnt_fail (cnt_fail)
`endif
  );

  typedef struct { int n; bit corr; bit fail; } exp_t;
  typedef struct { int w; int n; bit corr; bit fail; } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   retired;
  bit   held = 1'b0;
  int   held_n;
  bit   held_corr, held_fail;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference decode: search for the smallest single error +/-2^i making W a multiple of A
  function automatic exp_t model(input int w);
    exp_t r;
    int   e, c;
    bit   hit;
    hit = (w % SA == 0);
    e   = 0;
    for (int i = 0; i < int'(CW_W); i++) begin
      if (!hit) begin
        if ((w - (1 << i)) % SA == 0) begin hit = 1'b1; e = (1 << i); end
        else if ((w + (1 << i)) % SA == 0) begin hit = 1'b1; e = -(1 << i); end
      end
    end
    c      = w - e;
    r.fail = !hit || (c < 0) || (c > SA * ((1 << D_W) - 1));
    r.n    = r.fail ? 0 : c / SA;
    r.corr = !r.fail && (e != 0);
    return r;
  endfunction

  // One cycle of stream traffic, scoreboarded against the model
  task automatic step(input bit iv, input int w, input bit ordy, output bit acc);
    exp_t e;
    @(negedge clk);
    if (held) begin
      chk("stall_valid", int'(bus.out_valid), 1);
      chk("stall_n", int'(bus.out_n), held_n);
      chk("stall_corr", int'(bus.out_corr), int'(held_corr));
      chk("stall_fail", int'(bus.out_fail), int'(held_fail));
    end
    bus.in_valid  = iv;
    bus.in_w      = CW_W'(w);
    bus.out_ready = ordy;
    #1;
    acc = iv && bus.in_ready;
    if (bus.out_valid && ordy) begin
      retired++;
      if (q.size() == 0) chk("spurious_out", int'(bus.out_valid), 0);
      else begin
        e = q.pop_front();
        chk("sb_n", int'(bus.out_n), e.n);
        chk("sb_corr", int'(bus.out_corr), int'(e.corr));
        chk("sb_fail", int'(bus.out_fail), int'(e.fail));
      end
    end
    if (acc) q.push_back(model(w));
    held      = bus.out_valid && !ordy;
    held_n    = int'(bus.out_n);
    held_corr = bus.out_corr;
    held_fail = bus.out_fail;
  endtask

  // Single isolated word: check acceptance, 3-cycle latency and result
  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_w      = CW_W'(v.w);
    bus.out_ready = 1'b1;
    #1 chk($sformatf("in_ready_idle w=%0d", v.w), int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("latency w=%0d", v.w), cyc, 3);
    chk($sformatf("n w=%0d", v.w), int'(bus.out_n), v.n);
    chk($sformatf("corr w=%0d", v.w), int'(bus.out_corr), int'(v.corr));
    chk($sformatf("fail w=%0d", v.w), int'(bus.out_fail), int'(v.fail));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[10];
    int   words[4];
    int   idx;
    bit   acc;

    vecs[0] = '{26, 2, 1'b0, 1'b0};
    vecs[1] = '{27, 2, 1'b1, 1'b0};
    vecs[2] = '{35, 3, 1'b1, 1'b0};
    vecs[3] = '{12, 1, 1'b1, 1'b0};
    vecs[4] = '{63, 0, 1'b0, 1'b1};
    vecs[5] = '{1,  0, 1'b1, 1'b0};
    vecs[6] = '{0,  0, 1'b0, 1'b0};
    vecs[7] = '{39, 3, 1'b0, 1'b0};
    vecs[8] = '{40, 3, 1'b1, 1'b0};
    vecs[9] = '{52, 0, 1'b0, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_w      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_n", int'(bus.out_n), 0);
    chk("rst_out_corr", int'(bus.out_corr), 0);
    chk("rst_out_fail", int'(bus.out_fail), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
`ifdef AN_DEC_STATS_EN
      if (i == 5) begin
        @(negedge clk);
        chk("stats_corr", int'(cnt_corr), 4);
        chk("stats_fail", int'(cnt_fail), 1);
      end
`endif
    end
    @(negedge clk);

    // Backpressure: 4 back-to-back words, consumer stalls 5 cycles on the first result
    words   = '{26, 27, 35, 12};
    idx     = 0;
    retired = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      step(idx < 4, (idx < 4) ? words[idx] : 0, !(cyc >= 3 && cyc < 8), acc);
      if (cyc == 3) chk("bp_first_valid", int'(bus.out_valid), 1);
      if (cyc >= 3 && cyc < 8) chk("bp_in_ready", int'(bus.in_ready), 0);
      if (acc) idx++;
    end
    chk("bp_retired", retired, 4);
    chk("bp_q_empty", q.size(), 0);

    // Random traffic with random backpressure
    for (int k = 0; k < 500; k++)
      step($urandom % 4 != 0, int'($urandom_range(0, 63)), $urandom % 3 != 0, acc);
    for (int k = 0; k < 12; k++) step(1'b0, 0, 1'b1, acc);
    chk("rand_q_empty", q.size(), 0);

    // Reset with three words in flight
    step(1'b1, 26, 1'b1, acc);
    step(1'b1, 27, 1'b1, acc);
    step(1'b1, 35, 1'b1, acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_out_n", int'(bus.out_n), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    q.delete();
    held = 1'b0;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    retired = 0;
    for (int k = 0; k < 8; k++) step(1'b0, 0, 1'b1, acc);
    chk("midrst_no_stale", retired, 0);

`ifdef AN_DEC_STATS_EN
    // Saturation: more than 65535 failing words
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_w      = CW_W'(63);
    repeat (65600) @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("sat_cnt_fail", int'(cnt_fail), 65535);
    chk("sat_cnt_corr", int'(cnt_corr), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
